// File: rtl/vga_fill_arbiter.sv
// Shares the framebuffer write port between CPU pixel writes and a
// rectangle-fill engine; the CPU always wins, the engine stalls.
module vga_fill_arbiter #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PIXEL_COUNT = H_RES * V_RES
) (
  input  logic        clk_cpu,
  input  logic        reset_n,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        fill_start,
  input  logic        fill_abort,
  input  logic [9:0]  fill_x0,
  input  logic [9:0]  fill_y0,
  input  logic [9:0]  fill_w,
  input  logic [9:0]  fill_h,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        fb_wr,
  output logic [31:0] fb_addr,
  output logic [7:0]  fb_data
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [9:0]  x0_q, x0_d, y0_q, y0_d;
  logic [9:0]  w_q, w_d, h_q, h_d;
  logic [7:0]  color_q, color_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] x_end_q, x_end_d;
  logic [10:0] y_end_q, y_end_d;
  logic [31:0] row_base_q, row_base_d;
  logic        fb_wr_q, fb_wr_d;
  logic [31:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_data_q, fb_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [10:0] x_sum, y_sum;
  logic        empty;

  assign x_sum = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum = {1'b0, y0_q} + {1'b0, h_q};
  assign empty = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x0_q} >= 11'(H_RES)) ||
                 ({1'b0, y0_q} >= 11'(V_RES));

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    fb_wr_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    busy_d     = (state_q == SETUP) || (state_q == RUN);
    done_d     = (state_q == DONE);
    if (cpu_wr) begin
      fb_wr_d   = 1'b1;
      fb_addr_d = cpu_addr;
      fb_data_d = cpu_data;
    end
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          x0_d    = fill_x0;
          y0_d    = fill_y0;
          w_d     = fill_w;
          h_d     = fill_h;
          color_d = fill_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        x_end_d    = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
        y_end_d    = (y_sum > 11'(V_RES)) ? 11'(V_RES) : y_sum;
        row_base_d = 32'(y0_q) * 32'(H_RES);
        x_d        = {1'b0, x0_q};
        y_d        = {1'b0, y0_q};
        state_d    = (empty || fill_abort) ? DONE : RUN;
      end
      RUN: begin
        // A CPU write steals the port; counters hold so nothing is skipped.
        if (!cpu_wr) begin
          fb_wr_d   = 1'b1;
          fb_addr_d = row_base_q + 32'(x_q);
          fb_data_d = color_q;
          if (x_q + 11'd1 == x_end_q) begin
            x_d        = {1'b0, x0_q};
            y_d        = y_q + 11'd1;
            row_base_d = row_base_q + 32'(H_RES);
            if (y_q + 11'd1 == y_end_q)
              state_d = DONE;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
        if (fill_abort)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      fb_wr_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      fb_wr_q    <= fb_wr_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fill_busy = busy_q;
  assign fill_done = done_q;
  assign fb_wr     = fb_wr_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;

  // Clipping keeps every fill address inside the framebuffer.
  a_fill_in_range: assert property (@(posedge clk_cpu) disable iff (!reset_n)
    (state_q == RUN && !cpu_wr) |-> (row_base_q + 32'(x_q) < 32'(PIXEL_COUNT)));

endmodule
